// File: rtl/serial_detect_arbiter_if.sv
// Serial request bus and detection result bus for serial_detect_arbiter.
interface serial_detect_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int PAT_W = 4
);
    logic [PAT_W-1:0] cfg_pattern;
    logic [NREQ-1:0]  bit_valid;
    logic [NREQ-1:0]  bit_data;
    logic [NREQ-1:0]  bit_last;
    logic [NREQ-1:0]  bit_ready;
    logic             detect;
    logic [2:0]       detect_id;
    logic             done;
    logic [2:0]       done_id;
    logic [7:0]       match_cnt;
    logic             aborted;

    modport master (
        output cfg_pattern, bit_valid, bit_data, bit_last,
        input  bit_ready, detect, detect_id, done, done_id, match_cnt, aborted
    );

    modport slave (
        input  cfg_pattern, bit_valid, bit_data, bit_last,
        output bit_ready, detect, detect_id, done, done_id, match_cnt, aborted
    );
endinterface

// File: rtl/serial_detect_arbiter.sv
// Round-robin sharing of one bit-serial overlapping pattern detector among NREQ requesters.
// Optional stall timeout on the granted requester is enabled by defining GRANT_TIMEOUT_EN.
module serial_detect_arbiter #(
    parameter int NREQ    = 4,
    parameter int PAT_W   = 4,
    parameter int TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_detect_arbiter_if.slave bus
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(PAT_W + 1);

    if (NREQ < 2 || NREQ > 8 || PAT_W < 2 || PAT_W > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("serial_detect_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [GW-1:0]    grant, rr_ptr, pick;
    logic             any_req;
    logic [NREQ-1:0]  onehot;
    logic [PAT_W-1:0] pat_reg, sh_nxt;
    logic [PAT_W-2:0] sh;
    logic [CW-1:0]    bitcnt;
    logic [7:0]       mcnt;
    logic             detect_q, aborted_q;
    logic             accept, cur_bit, cur_last, is_match, timed_out;
    logic [GW-1:0]    idx_g;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // First requester at or after rr_ptr; scanning downward lets the nearest one win.
    always_comb begin
        pick    = rr_ptr;
        any_req = 1'b0;
        idx_g   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (int'(rr_ptr) + i >= NREQ) idx_g = GW'(int'(rr_ptr) + i - NREQ);
            else                          idx_g = GW'(int'(rr_ptr) + i);
            if (bus.bit_valid[idx_g]) begin
                pick    = idx_g;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        onehot        = '0;
        onehot[grant] = 1'b1;
    end

    always_comb begin
        cur_bit   = bus.bit_data[grant];
        cur_last  = bus.bit_last[grant];
        accept    = (state == BUSY) && bus.bit_valid[grant];
        sh_nxt    = {sh, cur_bit};
        is_match  = accept && (bitcnt >= CW'(PAT_W - 1)) && (sh_nxt == pat_reg);
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if ((accept && cur_last) || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            detect_q <= 1'b0;
            mcnt     <= '0;
        end else begin
            state    <= state_nxt;
            detect_q <= is_match;
            if (state == IDLE && any_req) begin
                grant <= pick;
                mcnt  <= '0;
            end
            if (is_match) mcnt <= sat_inc8(mcnt);
            if (state == DONE) rr_ptr <= (grant == GW'(NREQ - 1)) ? '0 : grant + GW'(1);
        end
    end

    // Pattern window and bit count are reloaded at every grant, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            pat_reg <= bus.cfg_pattern;
            sh      <= '0;
            bitcnt  <= '0;
        end else if (accept) begin
            sh <= sh_nxt[PAT_W-2:0];
            if (bitcnt != CW'(PAT_W)) bitcnt <= bitcnt + CW'(1);
        end
    end

`ifdef GRANT_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall;

    assign timed_out = (state == BUSY) && !accept && (stall == SW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall     <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (state != BUSY || accept) stall <= '0;
            else                         stall <= stall + SW'(1);
            if (timed_out)                  aborted_q <= 1'b1;
            else if (accept && cur_last)    aborted_q <= 1'b0;
        end
    end
`else
    assign timed_out = 1'b0;
    assign aborted_q = 1'b0;
`endif

    assign bus.bit_ready = (state == BUSY) ? onehot : '0;
    assign bus.detect    = detect_q;
    assign bus.detect_id = 3'(grant);
    assign bus.done      = (state == DONE);
    assign bus.done_id   = 3'(grant);
    assign bus.match_cnt = mcnt;
    assign bus.aborted   = aborted_q;
endmodule
